// File: rtl/misr_compactor.sv
// misr_compactor: multiple-input signature register that folds PATTERNS
// accepted responses into an N-bit signature, then compares it against a
// golden value to produce one pass/fail verdict per session.
// Optional feature: define MISR_XMASK_EN to add mask_in, which zeroes the
// selected (unknown) response bits before they are folded.
module misr_compactor #(
   parameter int unsigned  N        = 8,
   parameter logic [N-1:0] POLY     = N'('h1D),
   parameter logic [N-1:0] SEED     = '0,
   parameter int unsigned  PATTERNS = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         valid_in,
   output logic         ready_out,
   input  logic [N-1:0] data_in,
`ifdef MISR_XMASK_EN
   input  logic [N-1:0] mask_in,
`endif
   input  logic [N-1:0] golden,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [N-1:0] signature
);

   localparam int unsigned CW = $clog2(PATTERNS + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   signature_q, signature_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           pass_q, pass_d;
   logic           ready_q, ready_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic [N-1:0]   fold_term;
   logic [N-1:0]   sig_next;
   logic           beat;

   // Response term folded this cycle (optionally with unknown bits masked off)
   always_comb begin
`ifdef MISR_XMASK_EN
      fold_term = data_in & ~mask_in;
`else
      fold_term = data_in;
`endif
      sig_next  = {signature_q[N-2:0], 1'b0}
                ^ (signature_q[N-1] ? POLY : '0)
                ^ fold_term;
      beat      = valid_in & ready_q;
   end

   // Next-state, signature, counter and verdict logic
   always_comb begin
      state_d     = state_q;
      signature_d = signature_q;
      cnt_d       = cnt_q;
      pass_d      = pass_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_RUN;
               signature_d = SEED;
               cnt_d       = '0;
            end
         end
         S_RUN: begin
            if (beat) begin
               signature_d = sig_next;
               cnt_d       = cnt_q + CW'(1);
               if (cnt_q == CW'(PATTERNS - 1)) begin
                  state_d = S_DONE;
                  pass_d  = (sig_next == golden);
               end
            end
         end
         S_DONE: begin
            if (start) begin
               state_d     = S_RUN;
               signature_d = SEED;
               cnt_d       = '0;
               pass_d      = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      ready_d = (state_d == S_RUN);
      busy_d  = (state_d == S_RUN);
      done_d  = (state_d == S_DONE);
   end

   // State and output registers; reset discards any session in progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         signature_q <= SEED;
         cnt_q       <= '0;
         pass_q      <= 1'b0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         signature_q <= signature_d;
         cnt_q       <= cnt_d;
         pass_q      <= pass_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign ready_out = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign signature = signature_q;

endmodule

// File: tb/tb_misr_compactor.sv
// Bench for misr_compactor (N=4, POLY=3, SEED=0, PATTERNS=3): random sessions
// with a queue of expected per-beat signatures and end-of-session verdicts.
module tb_misr_compactor;

   localparam int unsigned N        = 4;
   localparam logic [3:0]  POLY     = 4'h3;
   localparam logic [3:0]  SEED     = 4'h0;
   localparam int unsigned PATTERNS = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       valid_in;
   logic       ready_out;
   logic [3:0] data_in;
`ifdef MISR_XMASK_EN
   logic [3:0] mask_in;
`endif
   logic [3:0] golden;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] signature;

   typedef struct {
      logic [3:0] sig;
      bit         last;
      bit         pass;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   misr_compactor #(
      .N(N), .POLY(POLY), .SEED(SEED), .PATTERNS(PATTERNS)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .valid_in(valid_in),
      .ready_out(ready_out), .data_in(data_in),
`ifdef MISR_XMASK_EN
      .mask_in(mask_in),
`endif
      .golden(golden), .busy(busy), .done(done), .pass(pass),
      .signature(signature)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Signature register as polynomial arithmetic: multiply by x, reduce, add response
   function automatic logic [3:0] fold(input logic [3:0] s, input logic [3:0] d);
      int unsigned t;
      t = int'(s) * 2;
      if (t >= 16) t = (t - 16) ^ int'(POLY);
      return 4'(t) ^ d;
   endfunction

   // Monitor: compares signature after every accepted beat, holds otherwise
   initial begin
      logic [3:0] cur;
      bit         b;
      bit         st;
      exp_t       e;
      cur = SEED;
      forever begin
         @(posedge clk);
         b  = valid_in & ready_out;
         st = start & ~busy;
         #1;
         if (rst) begin
            cur = SEED;
         end else if (b) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL beat_unexpected: got beat expected none at %0t", $time);
            end else begin
               e = sb.pop_front();
               check("sig_after_beat", 32'(signature), 32'(e.sig));
               cur = e.sig;
               if (e.last) begin
                  check("done_after_last", 32'(done), 32'(1));
                  check("pass_verdict", 32'(pass), 32'(e.pass));
                  check("ready_after_last", 32'(ready_out), 32'(0));
                  check("busy_after_last", 32'(busy), 32'(0));
               end
            end
         end else begin
            if (st) cur = SEED;
            check("sig_hold", 32'(signature), 32'(cur));
         end
      end
   end

   // One session: optional idle gaps and ignored starts; abort_at>=0 resets after that beat
   task automatic session(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                          input bit want_pass, input int abort_at);
      logic [3:0] d[3];
      logic [3:0] m[3];
      logic [3:0] es[3];
      logic [3:0] s;
      logic [3:0] g;
      d = '{d0, d1, d2};
      s = SEED;
      for (int i = 0; i < 3; i++) begin
`ifdef MISR_XMASK_EN
         m[i] = 4'($urandom);
`else
         m[i] = 4'h0;
`endif
         s     = fold(s, d[i] & ~m[i]);
         es[i] = s;
      end
      g = want_pass ? s : (s ^ 4'($urandom_range(1, 15)));

      start    = 1'b1;
      valid_in = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check("start_busy", 32'(busy), 32'(1));
      check("start_done", 32'(done), 32'(0));
      check("start_ready", 32'(ready_out), 32'(1));
      check("start_sig_seed", 32'(signature), 32'(SEED));
      check("start_pass", 32'(pass), 32'(0));

      for (int i = 0; i < 3; i++) begin
         repeat ($urandom_range(0, 2)) begin
            valid_in = 1'b0;
            data_in  = 4'($urandom);
            start    = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
         start    = 1'b0;
         valid_in = 1'b1;
         data_in  = d[i];
`ifdef MISR_XMASK_EN
         mask_in  = m[i];
`endif
         golden   = (i == 2) ? g : 4'($urandom);
         sb.push_back('{es[i], (i == 2), want_pass});
         @(negedge clk);
         valid_in = 1'b0;
         if (abort_at == i) begin
            rst = 1'b1;
            #1;
            check("abort_sig", 32'(signature), 32'(SEED));
            check("abort_busy", 32'(busy), 32'(0));
            check("abort_done", 32'(done), 32'(0));
            check("abort_ready", 32'(ready_out), 32'(0));
            @(negedge clk);
            rst = 1'b0;
            return;
         end
      end

      // DONE: offered responses must not be absorbed; verdict frozen
      repeat (2) begin
         valid_in = 1'($urandom_range(0, 1));
         data_in  = 4'($urandom);
         golden   = 4'($urandom);
         @(negedge clk);
         check("done_held", 32'(done), 32'(1));
         check("pass_frozen", 32'(pass), 32'(want_pass));
         check("done_ready", 32'(ready_out), 32'(0));
      end
      valid_in = 1'b0;
   endtask

   // Stimulus
   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      valid_in = 1'b0;
      data_in  = 4'h0;
      golden   = 4'h0;
`ifdef MISR_XMASK_EN
      mask_in  = 4'h0;
`endif
      repeat (2) @(negedge clk);
      check("rst_sig", 32'(signature), 32'(SEED));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_ready", 32'(ready_out), 32'(0));
      check("rst_pass", 32'(pass), 32'(0));
      rst = 1'b0;
      @(negedge clk);
      check("idle_ready", 32'(ready_out), 32'(0));

      session(4'h1, 4'h2, 4'h4, 1'b1, -1);
      session(4'h1, 4'h2, 4'h4, 1'b0, -1);
      session(4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1);
      repeat (2) @(negedge clk);
      session(4'($urandom), 4'($urandom), 4'($urandom), 1'b1, -1);
      for (int k = 0; k < 20; k++) begin
         session(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
